// File: rtl/aardvark_pkg.sv
// Shared definitions for the ALU issue controller.
//   - opcode encodings presented on instr_op / alu_op
//   - ALU_IDLE: the opcode parked on alu_op between operations
//   - issue FSM state type
//   - is_alu_op(): true for opcodes that go through the ALU
package aardvark_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_CMP  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_EQ   = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  // Shares its encoding with OP_LDI; ldi never reaches the ALU, so the
  // ALU sees this code only while no operation is in flight.
  localparam logic [2:0] ALU_IDLE = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op <= OP_EQ);
  endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Small register file for the issue controller.
//   clk, rst         : clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata   : synchronous write port
//   raddr_a/rdata_a  : combinational read port A
//   raddr_b/rdata_b  : combinational read port B
module regfile_4x8 #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_reg [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_reg[raddr_a];
  assign rdata_b = mem_reg[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit alu block.
//   instr_*            : one decoded instruction, valid/ready handshake
//   alu_op/alu_a/alu_b : opcode and operands driven to the ALU
//   alu_result/zero    : ALU outputs, captured at the end of EXEC
//   wb_valid/addr/data : one-cycle writeback strobe (also writes the regfile)
//   br_taken/br_target : one-cycle branch pulse for a taken eq
//   err                : one-cycle pulse for the reserved opcode
// ALU ops take 4 cycles (IDLE, SETUP, EXEC, WB); ldi/reserved take 2.
module alu_issue_ctrl
  import aardvark_pkg::*;
#(
  parameter int NREG = 4,
  parameter int DW   = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic [DW-1:0] instr_imm,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          br_taken,
  output logic [DW-1:0] br_target,
  output logic          err
);

  state_t        state_reg;
  logic [2:0]    op_reg;
  logic [AW-1:0] rd_reg;
  logic [DW-1:0] imm_reg;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;

  // The writeback strobe doubles as the regfile write enable, so the write
  // lands at the end of the WB cycle and is visible to the next accept.
  regfile_4x8 #(.NREG(NREG), .DW(DW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (instr_rs),
    .rdata_a (rs_data),
    .raddr_b (instr_rt),
    .rdata_b (rt_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      instr_ready <= 1'b1;
      alu_op      <= ALU_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      br_taken    <= 1'b0;
      br_target   <= '0;
      err         <= 1'b0;
      op_reg      <= OP_ADD;
      rd_reg      <= '0;
      imm_reg     <= '0;
    end else begin
      // Pulses are raised on entry to WB only and drop by default.
      wb_valid <= 1'b0;
      br_taken <= 1'b0;
      err      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            op_reg      <= instr_op;
            rd_reg      <= instr_rd;
            imm_reg     <= instr_imm;
            instr_ready <= 1'b0;
            if (is_alu_op(instr_op)) begin
              alu_a     <= rs_data;
              alu_b     <= rt_data;
              state_reg <= ST_SETUP;
            end else begin
              // ldi and reserved bypass the ALU and pulse straight away.
              state_reg <= ST_WB;
              if (instr_op == OP_LDI) begin
                wb_valid <= 1'b1;
                wb_addr  <= instr_rd;
                wb_data  <= instr_imm;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        ST_SETUP: begin
          // Operands have been stable for this whole cycle; release the op.
          alu_op    <= op_reg;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          alu_op    <= ALU_IDLE;
          state_reg <= ST_WB;
          if (op_reg == OP_EQ) begin
            br_taken <= alu_zero;
            if (alu_zero) begin
              br_target <= imm_reg;
            end
          end else begin
            wb_valid <= 1'b1;
            wb_addr  <= rd_reg;
            wb_data  <= alu_result;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import aardvark_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs, instr_rt;
  logic [7:0] instr_imm;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_zero;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       br_taken;
  logic [7:0] br_target;
  logic       err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl #(.NREG(4), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .br_taken(br_taken), .br_target(br_target), .err(err)
  );

  // Behavioural stand-in for the team alu (combinational).
  function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = ~(a & b);
      3'b010:  r = {7'b0, (a < b)};
      3'b011:  r = {a[6:0], 1'b0};
      3'b100:  r = {a[7], a[7:1]};
      3'b101:  r = a ^ b;
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), r};
  endfunction

  assign {alu_zero, alu_result} = alu_model(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // sig 0 = alu_op, 1 = instr_ready
  typedef struct { int cyc; int sig; logic [7:0] val; } exp_t;
  // kind 0 = writeback, 1 = branch, 2 = err
  typedef struct { int cyc; int kind; logic [1:0] addr; logic [7:0] data; } pulse_t;

  exp_t   exp_q[$];
  pulse_t pulse_q[$];
  logic [7:0] model_rf [4];

  function automatic void push_exp(input int c, input int s, input logic [7:0] v);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_pulse(input int c, input int k, input logic [1:0] a, input logic [7:0] d);
    pulse_t p;
    p.cyc = c; p.kind = k; p.addr = a; p.data = d;
    pulse_q.push_back(p);
  endfunction

  // Monitor: checks timed expectations and pops the pulse scoreboard.
  exp_t   mon_e;
  pulse_t mon_p;
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.sig == 0) check("alu_op", {29'b0, alu_op}, {24'b0, mon_e.val});
        else                check("instr_ready", {31'b0, instr_ready}, {24'b0, mon_e.val});
      end
      if (wb_valid || br_taken || err) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", {29'b0, wb_valid, br_taken, err}, 32'h0);
        end else begin
          mon_p = pulse_q.pop_front();
          check("pulse_cycle", cyc, mon_p.cyc);
          check("pulse_kind", {29'b0, wb_valid, br_taken, err},
                (mon_p.kind == 0) ? 32'h4 : (mon_p.kind == 1) ? 32'h2 : 32'h1);
          $display("txn kind=%0d cycle=%0d addr=%0d data=0x%02h", mon_p.kind, cyc, mon_p.addr, mon_p.data);
          if (mon_p.kind == 0) begin
            check("wb_addr", {30'b0, wb_addr}, {30'b0, mon_p.addr});
            check("wb_data", {24'b0, wb_data}, {24'b0, mon_p.data});
          end else if (mon_p.kind == 1) begin
            check("br_target", {24'b0, br_target}, {24'b0, mon_p.data});
          end
        end
      end else if (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        mon_p = pulse_q.pop_front();
        check("missing_pulse", 32'h0, 32'h1);
      end
    end
  end

  // Drive one instruction (inputs change on negedge) and wait for its accept.
  // acc = cycle count seen at the negedge just after the accepting edge (T0+1).
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] imm, input bit track, output int acc);
    logic [8:0] zr;
    int budget;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    budget = 0;
    while (!instr_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 20) begin
        check("accept_timeout", 32'h0, 32'h1);
        acc = -1;
        return;
      end
    end
    acc = cyc + 1;
    if (track) begin
      if (op <= OP_EQ) begin
        zr = alu_model(op, model_rf[rs], model_rf[rt]);
        push_exp(acc, 0, {5'b0, ALU_IDLE});     push_exp(acc, 1, 8'd0);
        push_exp(acc + 1, 0, {5'b0, op});       push_exp(acc + 1, 1, 8'd0);
        push_exp(acc + 2, 0, {5'b0, ALU_IDLE}); push_exp(acc + 2, 1, 8'd0);
        push_exp(acc + 3, 1, 8'd1);
        if (op == OP_EQ) begin
          if (zr[8]) push_pulse(acc + 2, 1, 2'd0, imm);
        end else begin
          model_rf[rd] = zr[7:0];
          push_pulse(acc + 2, 0, rd, zr[7:0]);
        end
      end else begin
        push_exp(acc, 1, 8'd0);
        push_exp(acc + 1, 1, 8'd1);
        if (op == OP_LDI) begin
          model_rf[rd] = imm;
          push_pulse(acc, 0, rd, imm);
        end else begin
          push_pulse(acc, 2, 2'd0, 8'd0);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int a;
  int accs[4];

  initial begin
    rst = 1'b1; instr_valid = 1'b0;
    instr_op = 3'b0; instr_rd = 2'b0; instr_rs = 2'b0; instr_rt = 2'b0; instr_imm = 8'h0;
    for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'h1);
    check("rst_alu_op", {29'b0, alu_op}, 32'h6);
    check("rst_alu_ab", {16'b0, alu_a, alu_b}, 32'h0);
    check("rst_pulses", {29'b0, wb_valid, br_taken, err}, 32'h0);
    check("rst_wb", {22'b0, wb_addr, wb_data}, 32'h0);
    check("rst_br_target", {24'b0, br_target}, 32'h0);
    rst = 1'b0;

    // ldi then add
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05, 1'b1, a);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h07, 1'b1, a);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, a);
    settle();
    check("add_model_r3", {24'b0, model_rf[3]}, 32'h0C);

    // nand, compare and shifts
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hF0, 1'b1, a);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h3C, 1'b1, a);
    issue(OP_NAND, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, a);
    issue(OP_SHL, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, a);
    issue(OP_SRA, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, a);
    issue(OP_SRA, 2'd3, 2'd2, 2'd1, 8'h00, 1'b1, a);
    issue(OP_CMP, 2'd0, 2'd2, 2'd1, 8'h00, 1'b1, a);
    settle();

    // eq branch: taken, then not taken
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h42, 1'b1, a);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h42, 1'b1, a);
    issue(OP_EQ, 2'd0, 2'd1, 2'd2, 8'h10, 1'b1, a);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h43, 1'b1, a);
    issue(OP_EQ, 2'd0, 2'd1, 2'd2, 8'h20, 1'b1, a);
    settle();
    check("br_target_hold", {24'b0, br_target}, 32'h10);
    check("wb_data_hold", {24'b0, wb_data}, 32'h43);

    // back-to-back adds with instr_valid held high
    for (int i = 0; i < 4; i++) issue(OP_ADD, 2'd3, 2'd3, 2'd1, 8'h00, 1'b1, accs[i]);
    for (int i = 1; i < 4; i++) check("accept_spacing", accs[i] - accs[i-1], 32'd4);
    settle();

    // reserved opcode, then confirm rf untouched through an add
    issue(OP_RSV, 2'd1, 2'd0, 2'd0, 8'h99, 1'b1, a);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 1'b1, a);
    settle();

    // reset during EXEC of an add
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h33, 1'b1, a);
    issue(OP_ADD, 2'd3, 2'd1, 2'd1, 8'h00, 1'b0, a);
    @(negedge clk);               // SETUP
    instr_valid = 1'b0;
    @(negedge clk);               // EXEC
    check("exec_alu_op", {29'b0, alu_op}, {29'b0, OP_ADD});
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'b0, instr_ready}, 32'h1);
    check("abort_alu_op", {29'b0, alu_op}, 32'h6);
    check("abort_no_wb", {31'b0, wb_valid}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
    issue(OP_ADD, 2'd0, 2'd1, 2'd1, 8'h00, 1'b1, a);
    settle();
    check("post_reset_r1", {24'b0, wb_data}, 32'h00);

    check("pulse_q_drained", pulse_q.size(), 32'h0);
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
